// File: rtl/eu_param.sv
`default_nettype none
// ============================================================================
// Module   : eu_param
// Brief    : Parametrised execution unit. Fetches operands over the BIU
//            req/ack port, runs an ALU op and writes the result back.
// Revision : 1.0 - initial release
// ============================================================================
module eu_param #(
    parameter int DW      = 16,
    parameter int IRW     = 32,
    parameter int ALU_LAT = 1,
    parameter int TIMEOUT = 255
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [IRW-1:0] ir,
    input  logic           biu_ack,
    input  logic [DW-1:0]  biu_rdata,
    output logic           biu_req,
    output logic [1:0]     biu_op,
    output logic [DW-1:0]  biu_wdata,
    output logic           busy,
    output logic           done,
    output logic           err,
    output logic [3:0]     flags
);

    localparam logic [2:0] c_ST_IDLE = 3'd0;
    localparam logic [2:0] c_ST_RD_A = 3'd1;
    localparam logic [2:0] c_ST_RD_B = 3'd2;
    localparam logic [2:0] c_ST_EXEC = 3'd3;
    localparam logic [2:0] c_ST_WR   = 3'd4;
    localparam logic [2:0] c_ST_DONE = 3'd5;
    localparam logic [2:0] c_ST_ERR  = 3'd6;

    localparam logic [1:0] c_MODE_RI  = 2'b00;
    localparam logic [1:0] c_MODE_CMP = 2'b10;
    localparam logic [1:0] c_MODE_ILL = 2'b11;

    localparam logic [1:0] c_BOP_RD_A = 2'b00;
    localparam logic [1:0] c_BOP_RD_B = 2'b01;
    localparam logic [1:0] c_BOP_WR   = 2'b10;

    localparam logic [2:0] c_OP_ADD = 3'd0;
    localparam logic [2:0] c_OP_SUB = 3'd1;
    localparam logic [2:0] c_OP_AND = 3'd2;
    localparam logic [2:0] c_OP_OR  = 3'd3;
    localparam logic [2:0] c_OP_XOR = 3'd4;
    localparam logic [2:0] c_OP_NOT = 3'd5;
    localparam logic [2:0] c_OP_SHL = 3'd6;
    localparam logic [2:0] c_OP_SHR = 3'd7;

    localparam int              c_TW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_TW-1:0] c_TMO_LAST = c_TW'(TIMEOUT - 1);

    logic [2:0]      r_state;
    logic [2:0]      w_next;
    logic [1:0]      r_mode;
    logic [2:0]      r_op;
    logic [DW-1:0]   r_a;
    logic [DW-1:0]   r_b;
    logic [DW-1:0]   r_res;
    logic [3:0]      r_flags;
    logic [c_TW-1:0] r_tmo;

    logic            w_in_xfer;
    logic            w_xfer_done;
    logic            w_tmo_hit;
    logic            w_lat_last;
    logic [1:0]      w_ir_mode;
    logic [DW:0]     w_sum_add;
    logic [DW:0]     w_sum_sub;
    logic [DW-1:0]   w_res;
    logic            w_c;
    logic            w_v;
    logic [3:0]      w_flags;
    logic            w_unused_ir;

    assign w_ir_mode   = ir[IRW-1:IRW-2];
    assign w_unused_ir = ^ir;

    // A transfer is open in every requesting state; ack wins over a timeout on the same edge
    assign w_in_xfer   = (r_state == c_ST_RD_A) || (r_state == c_ST_RD_B) || (r_state == c_ST_WR);
    assign w_xfer_done = w_in_xfer && biu_ack;
    assign w_tmo_hit   = w_in_xfer && !biu_ack && (r_tmo == c_TMO_LAST);

    generate
        if (ALU_LAT == 1) begin : g_lat_single
            assign w_lat_last = 1'b1;
        end else begin : g_lat_multi
            localparam int              c_LW       = $clog2(ALU_LAT);
            localparam logic [c_LW-1:0] c_LAT_LAST = c_LW'(ALU_LAT - 1);
            logic [c_LW-1:0] r_lat;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_lat <= '0;
                end else if ((r_state == c_ST_EXEC) && (r_lat != c_LAT_LAST)) begin
                    r_lat <= r_lat + 1'b1;
                end else begin
                    r_lat <= '0;
                end
            end

            assign w_lat_last = (r_lat == c_LAT_LAST);
        end
    endgenerate

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (start) begin
                    w_next = (w_ir_mode == c_MODE_ILL) ? c_ST_ERR : c_ST_RD_A;
                end
            end
            c_ST_RD_A: begin
                if (w_xfer_done) begin
                    w_next = (r_mode == c_MODE_RI) ? c_ST_EXEC : c_ST_RD_B;
                end else if (w_tmo_hit) begin
                    w_next = c_ST_ERR;
                end
            end
            c_ST_RD_B: begin
                if (w_xfer_done) begin
                    w_next = c_ST_EXEC;
                end else if (w_tmo_hit) begin
                    w_next = c_ST_ERR;
                end
            end
            c_ST_EXEC: begin
                if (w_lat_last) begin
                    w_next = (r_mode == c_MODE_CMP) ? c_ST_DONE : c_ST_WR;
                end
            end
            c_ST_WR: begin
                if (w_xfer_done) begin
                    w_next = c_ST_DONE;
                end else if (w_tmo_hit) begin
                    w_next = c_ST_ERR;
                end
            end
            c_ST_DONE: w_next = c_ST_IDLE;
            c_ST_ERR:  w_next = c_ST_IDLE;
            default:   w_next = c_ST_IDLE;
        endcase
    end

    // Outputs decode straight from the state register so reset drops req at once
    always_comb begin
        biu_req = 1'b0;
        biu_op  = c_BOP_RD_A;
        busy    = (r_state != c_ST_IDLE);
        done    = (r_state == c_ST_DONE);
        err     = (r_state == c_ST_ERR);
        case (r_state)
            c_ST_RD_A: begin
                biu_req = 1'b1;
                biu_op  = c_BOP_RD_A;
            end
            c_ST_RD_B: begin
                biu_req = 1'b1;
                biu_op  = c_BOP_RD_B;
            end
            c_ST_WR: begin
                biu_req = 1'b1;
                biu_op  = c_BOP_WR;
            end
            default: begin
                biu_req = 1'b0;
                biu_op  = c_BOP_RD_A;
            end
        endcase
    end

    assign biu_wdata = r_res;
    assign flags     = r_flags;

    // ---------------------------------------------------------------- ALU
    always_comb begin
        w_sum_add = {1'b0, r_a} + {1'b0, r_b};
        w_sum_sub = {1'b0, r_a} + {1'b0, ~r_b} + {{DW{1'b0}}, 1'b1};
        w_res     = '0;
        w_c       = 1'b0;
        w_v       = 1'b0;
        case (r_op)
            c_OP_ADD: begin
                w_res = w_sum_add[DW-1:0];
                w_c   = w_sum_add[DW];
                w_v   = (r_a[DW-1] == r_b[DW-1]) && (w_sum_add[DW-1] != r_a[DW-1]);
            end
            c_OP_SUB: begin
                w_res = w_sum_sub[DW-1:0];
                w_c   = w_sum_sub[DW];
                w_v   = (r_a[DW-1] != r_b[DW-1]) && (w_sum_sub[DW-1] != r_a[DW-1]);
            end
            c_OP_AND: w_res = r_a & r_b;
            c_OP_OR:  w_res = r_a | r_b;
            c_OP_XOR: w_res = r_a ^ r_b;
            c_OP_NOT: w_res = ~r_a;
            c_OP_SHL: begin
                w_res = {r_a[DW-2:0], 1'b0};
                w_c   = r_a[DW-1];
            end
            c_OP_SHR: begin
                w_res = {1'b0, r_a[DW-1:1]};
                w_c   = r_a[0];
            end
            default: begin
                w_res = '0;
                w_c   = 1'b0;
            end
        endcase
        w_flags = {(w_res == '0), w_res[DW-1], w_c, w_v};
    end

    // ---------------------------------------------------------------- datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode  <= '0;
            r_op    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_flags <= '0;
            r_tmo   <= '0;
        end else begin
            if (r_state != w_next) begin
                r_tmo <= '0;
            end else if (w_in_xfer) begin
                r_tmo <= r_tmo + 1'b1;
            end

            // Immediate preloads B; reg-reg and compare overwrite it from the BIU
            if ((r_state == c_ST_IDLE) && start) begin
                r_mode <= w_ir_mode;
                r_op   <= ir[IRW-3:IRW-5];
                r_b    <= ir[DW-1:0];
            end

            if ((r_state == c_ST_RD_A) && biu_ack) begin
                r_a <= biu_rdata;
            end
            if ((r_state == c_ST_RD_B) && biu_ack) begin
                r_b <= biu_rdata;
            end

            if ((r_state == c_ST_EXEC) && w_lat_last) begin
                r_flags <= w_flags;
                if (r_mode != c_MODE_CMP) begin
                    r_res <= w_res;
                end
            end
        end
    end

endmodule
`default_nettype wire
